// File: rtl/config_shadow_store.sv
// config_shadow_store: double-buffered serial configuration store; frames shift into a shadow
// register and move to the active outputs on a length-checked commit. Optional macro: CONFIG_PARITY_EN.
`default_nettype none

module config_shadow_store #(
  parameter int                           ClockConfigWidth   = 4,
  parameter int                           NumCoeffs          = 4,
  parameter int                           CoeffWidth         = 8,
  parameter logic [ClockConfigWidth-1:0]  DefaultClockConfig = 4'hf,
  parameter logic                         DefaultSymCoeffs   = 1'b1,
  parameter logic [CoeffWidth-1:0]        DefaultCoeff       = '0
) (
  input  logic                             clk,
  input  logic                             resetN,
  input  logic                             serialEn,
  input  logic                             serialIn,
  output logic                             serialOut,
  input  logic                             commit,
  output logic [ClockConfigWidth-1:0]      clockConfig,
  output logic                             symCoeffs,
  output logic [NumCoeffs*CoeffWidth-1:0]  coeffs,
  output logic                             updated,
  output logic                             frameError
);

  localparam int CoeffBits  = NumCoeffs * CoeffWidth;
  localparam int FieldBits  = ClockConfigWidth + 1 + CoeffBits;
`ifdef CONFIG_PARITY_EN
  localparam int ParityBits = 1;
`else
  localparam int ParityBits = 0;
`endif
  localparam int FrameSize  = FieldBits + ParityBits;
  localparam int CountWidth = $clog2(FrameSize + 2);

  localparam logic [CountWidth-1:0] c_COUNT_FULL = CountWidth'(FrameSize);
  localparam logic [CountWidth-1:0] c_COUNT_OVF  = CountWidth'(FrameSize + 1);
  localparam logic [FieldBits-1:0]  c_DEF_FIELDS =
    {DefaultSymCoeffs, {NumCoeffs{DefaultCoeff}}, DefaultClockConfig};

  // The reset frame carries a matching parity bit so an untouched shadow is a valid frame.
`ifdef CONFIG_PARITY_EN
  localparam logic [FrameSize-1:0] c_DEF_FRAME = {c_DEF_FIELDS, ^c_DEF_FIELDS};
`else
  localparam logic [FrameSize-1:0] c_DEF_FRAME = c_DEF_FIELDS;
`endif

  logic [FrameSize-1:0]        r_shadow;
  logic [CountWidth-1:0]       r_bitCount;
  logic [ClockConfigWidth-1:0] r_clockConfig;
  logic                        r_symCoeffs;
  logic [CoeffBits-1:0]        r_coeffs;
  logic                        r_updated;
  logic                        r_frameError;
  logic                        w_parityOk;
  logic                        w_accept;

`ifdef CONFIG_PARITY_EN
  assign w_parityOk = ~(^r_shadow);
`else
  assign w_parityOk = 1'b1;
`endif

  assign w_accept = commit && !serialEn && (r_bitCount == c_COUNT_FULL) && w_parityOk;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_shadow      <= c_DEF_FRAME;
      r_bitCount    <= '0;
      r_clockConfig <= DefaultClockConfig;
      r_symCoeffs   <= DefaultSymCoeffs;
      r_coeffs      <= {NumCoeffs{DefaultCoeff}};
      r_updated     <= 1'b0;
      r_frameError  <= 1'b0;
    end else begin
      r_updated <= 1'b0;
      if (serialEn) begin
        r_shadow <= {r_shadow[FrameSize-2:0], serialIn};
        if (r_bitCount != c_COUNT_OVF) begin
          r_bitCount <= r_bitCount + 1'b1;
        end
      end else if (commit) begin
        r_bitCount <= '0;
      end
      // A commit overlapping a shift is always rejected; the shift itself still happens.
      if (commit) begin
        if (w_accept) begin
          r_symCoeffs   <= r_shadow[FrameSize-1];
          r_coeffs      <= r_shadow[ParityBits+ClockConfigWidth +: CoeffBits];
          r_clockConfig <= r_shadow[ParityBits +: ClockConfigWidth];
          r_updated     <= 1'b1;
          r_frameError  <= 1'b0;
        end else begin
          r_frameError  <= 1'b1;
        end
      end
    end
  end

  assign serialOut   = r_shadow[FrameSize-1];
  assign clockConfig = r_clockConfig;
  assign symCoeffs   = r_symCoeffs;
  assign coeffs      = r_coeffs;
  assign updated     = r_updated;
  assign frameError  = r_frameError;

endmodule

`default_nettype wire

// File: tb/tb_config_shadow_store.sv
// Directed self-checking bench for config_shadow_store (default parameters).
`default_nettype none

module tb_config_shadow_store;

`ifdef CONFIG_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FS = 37 + PAR;

  logic        clk = 1'b0;
  logic        resetN;
  logic        serialEn;
  logic        serialIn;
  logic        serialOut;
  logic        commit;
  logic [3:0]  clockConfig;
  logic        symCoeffs;
  logic [31:0] coeffs;
  logic        updated;
  logic        frameError;

  int checks = 0;
  int errors = 0;

  config_shadow_store dut (
    .clk         (clk),
    .resetN      (resetN),
    .serialEn    (serialEn),
    .serialIn    (serialIn),
    .serialOut   (serialOut),
    .commit      (commit),
    .clockConfig (clockConfig),
    .symCoeffs   (symCoeffs),
    .coeffs      (coeffs),
    .updated     (updated),
    .frameError  (frameError)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk_frame(input logic sym, input logic [31:0] c, input logic [3:0] cc);
    logic [36:0] f;
    f = {sym, c, cc};
`ifdef CONFIG_PARITY_EN
    return 64'({f, ^f});
`else
    return 64'(f);
`endif
  endfunction

  task automatic shift_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      serialEn = 1'b1;
      serialIn = v[i];
      tick();
    end
    serialEn = 1'b0;
    serialIn = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  logic [63:0] f1, f2, rb;

  initial begin
    f1 = mk_frame(1'b0, 32'h44332211, 4'h3);
    f2 = mk_frame(1'b1, 32'hA5C30F81, 4'h9);
    resetN = 1'b0; serialEn = 1'b0; serialIn = 1'b0; commit = 1'b0;
    tick(); tick();
    resetN = 1'b1;

    check("rst_clockConfig", 64'(clockConfig), 64'hf);
    check("rst_symCoeffs",   64'(symCoeffs),   64'h1);
    check("rst_coeffs",      64'(coeffs),      64'h0);
    check("rst_updated",     64'(updated),     64'h0);
    check("rst_frameError",  64'(frameError),  64'h0);
    check("rst_serialOut",   64'(serialOut),   64'h1);

    // Short frame
    shift_bits(f1, FS - 1);
    do_commit();
    check("short_frameError",  64'(frameError),  64'h1);
    check("short_updated",     64'(updated),     64'h0);
    check("short_clockConfig", 64'(clockConfig), 64'hf);

    // Long frame: counter saturates in overflow
    shift_bits(f1, FS + 3);
    do_commit();
    check("long_frameError", 64'(frameError), 64'h1);
    check("long_updated",    64'(updated),    64'h0);
    check("long_coeffs",     64'(coeffs),     64'h0);
    check("long_symCoeffs",  64'(symCoeffs),  64'h1);

    // Valid frame
    shift_bits(f1, FS);
    do_commit();
    check("valid_clockConfig", 64'(clockConfig), 64'h3);
    check("valid_symCoeffs",   64'(symCoeffs),   64'h0);
    check("valid_coeffs",      64'(coeffs),      64'h44332211);
    check("valid_updated",     64'(updated),     64'h1);
    check("valid_frameError",  64'(frameError),  64'h0);
    tick();
    check("valid_updated_fall", 64'(updated), 64'h0);

    // Readback, recirculating serialOut so the shadow is preserved
    rb = '0;
    for (int i = FS - 1; i >= 0; i--) begin
      rb[i]    = serialOut;
      serialEn = 1'b1;
      serialIn = serialOut;
      tick();
    end
    serialEn = 1'b0;
    check("readback_seq", rb, f1);

    // Commit during a shift
    serialEn = 1'b1; serialIn = 1'b0; commit = 1'b1;
    tick();
    serialEn = 1'b0; commit = 1'b0;
    check("simul_frameError",  64'(frameError),  64'h1);
    check("simul_updated",     64'(updated),     64'h0);
    check("simul_clockConfig", 64'(clockConfig), 64'h3);
    do_commit();

    // Back-to-back commits
    shift_bits(f2, FS);
    do_commit();
    check("b2b1_clockConfig", 64'(clockConfig), 64'h9);
    check("b2b1_symCoeffs",   64'(symCoeffs),   64'h1);
    check("b2b1_coeffs",      64'(coeffs),      64'hA5C30F81);
    check("b2b1_updated",     64'(updated),     64'h1);
    check("b2b1_frameError",  64'(frameError),  64'h0);
    do_commit();
    check("b2b2_frameError",  64'(frameError),  64'h1);
    check("b2b2_updated",     64'(updated),     64'h0);
    check("b2b2_coeffs",      64'(coeffs),      64'hA5C30F81);

    // Reset mid-frame
    shift_bits(f1, 20);
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    check("midrst_clockConfig", 64'(clockConfig), 64'hf);
    check("midrst_coeffs",      64'(coeffs),      64'h0);
    check("midrst_serialOut",   64'(serialOut),   64'h1);
    check("midrst_frameError",  64'(frameError),  64'h0);
    do_commit();
    check("midrst_commit_err",  64'(frameError),  64'h1);
    check("midrst_commit_cc",   64'(clockConfig), 64'hf);

`ifdef CONFIG_PARITY_EN
    shift_bits(f1, FS);
    do_commit();
    check("par_ok_frameError", 64'(frameError), 64'h0);
    check("par_ok_coeffs",     64'(coeffs),     64'h44332211);
    shift_bits(f2 ^ 64'h1, FS);
    do_commit();
    check("par_bad_frameError", 64'(frameError), 64'h1);
    check("par_bad_coeffs",     64'(coeffs),     64'h44332211);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
